// File: rtl/cover_toggle_drain.sv
// Toggle-coverage drain: latches per-point hits once per epoch and reports them
// round-robin as global cover indices on a valid/ready channel.
module cover_toggle_drain #(
    parameter int WIDTH       = 40,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8744,
    parameter int IDX_W       = 32,
    localparam int PTR_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CNT_W      = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_covered
);

    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_drain: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             all_covered_q, all_covered_d;
    // Set when the in-flight report belongs to an epoch that clear has since wiped.
    logic             stale_q, stale_d;

    logic [WIDTH-1:0] newhit;
    logic             load;
    logic             accept;
    logic             sel_found;
    logic [PTR_W-1:0] sel;
    logic [PTR_W:0]   scan;

    // Round-robin pick: first pending bit at or after ptr, wrapping at WIDTH-1.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        scan      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            scan = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (scan >= (PTR_W + 1)'(WIDTH)) begin
                scan = scan - (PTR_W + 1)'(WIDTH);
            end
            if (!sel_found && pending_q[scan[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel       = scan[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        newhit        = valid & ~seen_q & {WIDTH{en}};
        load          = !out_valid_q || out_ready;
        accept        = out_valid_q && out_ready;
        seen_d        = seen_q;
        pending_d     = pending_q;
        ptr_d         = ptr_q;
        out_valid_d   = out_valid_q;
        out_index_d   = out_index_q;
        hit_count_d   = hit_count_q;
        all_covered_d = all_covered_q;
        stale_d       = stale_q;

        if (clear) begin
            seen_d        = '0;
            pending_d     = '0;
            ptr_d         = '0;
            hit_count_d   = '0;
            all_covered_d = 1'b0;
            if (out_valid_q && !out_ready) begin
                stale_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
                stale_d     = 1'b0;
            end
        end else begin
            pending_d = pending_q | newhit;
            if (accept && !stale_q && hit_count_q != CNT_W'(WIDTH)) begin
                hit_count_d = hit_count_q + 1'b1;
            end
            if (load) begin
                stale_d = 1'b0;
                if (sel_found) begin
                    out_valid_d    = 1'b1;
                    out_index_d    = IDX_W'(COVER_INDEX) + IDX_W'(sel);
                    seen_d[sel]    = 1'b1;
                    pending_d[sel] = 1'b0;
                    ptr_d          = (sel == PTR_W'(WIDTH - 1)) ? '0 : sel + 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            all_covered_d = (hit_count_d == CNT_W'(WIDTH));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seen_q        <= '0;
            pending_q     <= '0;
            ptr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            hit_count_q   <= '0;
            all_covered_q <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            seen_q        <= seen_d;
            pending_q     <= pending_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            hit_count_q   <= hit_count_d;
            all_covered_q <= all_covered_d;
            stale_q       <= stale_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign hit_count   = hit_count_q;
    assign all_covered = all_covered_q;

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Bench for cover_toggle_drain: directed scenarios plus a randomized run
// against a behavioural model of the drain.
module tb_cover_toggle_drain;

    localparam int W    = 40;
    localparam int BASE = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  valid = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_index;
    logic [5:0]    hit_count;
    logic          all_covered;

    int errors = 0;
    int checks = 0;

    cover_toggle_drain #(
        .WIDTH(W), .COVER_INDEX(BASE), .COVER_TOTAL(8744), .IDX_W(32)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .clear(clear), .valid(valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .hit_count(hit_count), .all_covered(all_covered)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        en = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [W-1:0] bits3(input int a, input int b, input int c);
        logic [W-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_index !== 32'd0) begin errors++; $display("FAIL reset_out_index got=%0d exp=0", out_index); end
        checks++; if (hit_count !== 6'd0) begin errors++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
        checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL reset_all_covered got=%0b exp=0", all_covered); end
    endtask

    task automatic test_single_hit();
        int seen_valid;
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        valid = bits3(5, -1, -1);
        tick();
        valid = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 32'd105) begin errors++; $display("FAIL single_report got=%0b/%0d exp=1/105", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b0 || hit_count !== 6'd1) begin errors++; $display("FAIL single_done got=%0b/%0d exp=0/1", out_valid, hit_count); end
        valid = bits3(5, -1, -1);
        tick();
        valid = '0;
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid++;
        end
        checks++; if (seen_valid != 0 || hit_count !== 6'd1) begin errors++; $display("FAIL single_repeat got=%0d/%0d exp=0/1", seen_valid, hit_count); end
    endtask

    task automatic test_round_robin();
        int exp_a[3] = '{100, 103, 139};
        int exp_b[2] = '{101, 138};
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        valid = bits3(0, 3, 39);
        tick();
        valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 32'(exp_a[i])) begin errors++; $display("FAIL rr_first[%0d] got=%0b/%0d exp=1/%0d", i, out_valid, out_index, exp_a[i]); end
        end
        valid = bits3(1, 38, -1);
        tick();
        valid = '0;
        checks++; if (out_valid !== 1'b0 || hit_count !== 6'd3) begin errors++; $display("FAIL rr_gap got=%0b/%0d exp=0/3", out_valid, hit_count); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 32'(exp_b[i])) begin errors++; $display("FAIL rr_wrap[%0d] got=%0b/%0d exp=1/%0d", i, out_valid, out_index, exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        int exp_c[3] = '{110, 120, 102};
        int unstable;
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        valid = bits3(2, 10, 20);
        tick();
        valid = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 32'd102) begin errors++; $display("FAIL bp_first got=%0b/%0d exp=1/102", out_valid, out_index); end
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_index !== 32'd102 || hit_count !== 6'd0) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", unstable); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 32'(exp_c[i]) || hit_count !== 6'(i + 1)) begin errors++; $display("FAIL bp_release[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", i, out_valid, out_index, hit_count, exp_c[i], i + 1); end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || hit_count !== 6'd3) begin errors++; $display("FAIL bp_done got=%0b/%0d exp=0/3", out_valid, hit_count); end
    endtask

    task automatic test_all_bits();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        valid = '1;
        tick();
        valid = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 32'(BASE + i)) begin errors++; $display("FAIL all_seq[%0d] got=%0b/%0d exp=1/%0d", i, out_valid, out_index, BASE + i); end
        end
        checks++; if (all_covered !== 1'b0 || hit_count !== 6'd39) begin errors++; $display("FAIL all_before got=%0b/%0d exp=0/39", all_covered, hit_count); end
        tick();
        checks++; if (all_covered !== 1'b1 || hit_count !== 6'd40 || out_valid !== 1'b0) begin errors++; $display("FAIL all_done got=%0b/%0d/%0b exp=1/40/0", all_covered, hit_count, out_valid); end
        valid = '1;
        tick();
        valid = '0;
        tick();
        tick();
        checks++; if (all_covered !== 1'b1 || hit_count !== 6'd40 || out_valid !== 1'b0) begin errors++; $display("FAIL all_sticky got=%0b/%0d/%0b exp=1/40/0", all_covered, hit_count, out_valid); end
    endtask

    task automatic test_en_clear();
        int seen_valid;
        apply_reset();
        en = 1'b0; out_ready = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            valid = '1;
            tick();
            if (out_valid === 1'b1) seen_valid++;
        end
        valid = '0;
        tick();
        tick();
        if (out_valid === 1'b1) seen_valid++;
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL en_off got=%0d reports exp=0", seen_valid); end
        en = 1'b1; out_ready = 1'b0;
        valid = bits3(7, 12, 30);
        tick();
        valid = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 32'd107) begin errors++; $display("FAIL clr_setup got=%0b/%0d exp=1/107", out_valid, out_index); end
        clear = 1'b1;
        valid = bits3(3, -1, -1);
        tick();
        clear = 1'b0;
        valid = '0;
        checks++; if (out_valid !== 1'b1 || out_index !== 32'd107 || hit_count !== 6'd0) begin errors++; $display("FAIL clr_keep got=%0b/%0d/%0d exp=1/107/0", out_valid, out_index, hit_count); end
        out_ready = 1'b1;
        tick();
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) seen_valid++;
            tick();
        end
        checks++; if (seen_valid != 0 || hit_count !== 6'd0) begin errors++; $display("FAIL clr_flush got=%0d/%0d exp=0/0", seen_valid, hit_count); end
        valid = bits3(7, -1, -1);
        tick();
        valid = '0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 32'd107) begin errors++; $display("FAIL clr_restrobe got=%0b/%0d exp=1/107", out_valid, out_index); end
        tick();
        checks++; if (hit_count !== 6'd1) begin errors++; $display("FAIL clr_count got=%0d exp=1", hit_count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; out_ready = 1'b0;
        valid = bits3(3, 9, -1);
        tick();
        valid = '0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_setup got=%0b exp=1", out_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_index !== 32'd0) begin errors++; $display("FAIL ar_immediate got=%0b/%0d exp=0/0", out_valid, out_index); end
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0 || hit_count !== 6'd0 || all_covered !== 1'b0) begin errors++; $display("FAIL ar_after got=%0b/%0d/%0b exp=0/0/0", out_valid, hit_count, all_covered); end
    endtask

    // Behavioural model: hits become "waiting" points; each cycle the sink may
    // take one, the next chosen by a circular search starting after the last.
    task automatic test_random();
        bit     m_seen[W];
        bit     m_wait[W];
        int     m_next;
        bit     m_ov;
        int     m_idx;
        int     m_cnt;
        bit     m_old;
        bit     e, c, r;
        logic [63:0] a, b;
        logic [W-1:0] v;
        int     pick;
        bit     fresh[W];

        apply_reset();
        for (int k = 0; k < W; k++) begin m_seen[k] = 0; m_wait[k] = 0; end
        m_next = 0; m_ov = 0; m_idx = 0; m_cnt = 0; m_old = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            v = (cyc % 100 < 50) ? (a[W-1:0] & b[W-1:0] & W'({$urandom(), $urandom()})) : '0;
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 59) == 0);
            valid = v; en = e; out_ready = r; clear = c;

            if (c) begin
                for (int k = 0; k < W; k++) begin m_seen[k] = 0; m_wait[k] = 0; end
                m_next = 0; m_cnt = 0;
                if (m_ov && !r) m_old = 1;
                else m_ov = 0;
            end else begin
                for (int k = 0; k < W; k++) fresh[k] = e && v[k] && !m_seen[k];
                if (m_ov && r && !m_old && m_cnt < W) m_cnt++;
                if (!m_ov || r) begin
                    m_old = 0;
                    pick = -1;
                    for (int k = 0; k < W && pick < 0; k++)
                        if (m_wait[(m_next + k) % W]) pick = (m_next + k) % W;
                    for (int k = 0; k < W; k++) if (fresh[k]) m_wait[k] = 1;
                    if (pick >= 0) begin
                        m_ov = 1; m_idx = BASE + pick;
                        m_seen[pick] = 1; m_wait[pick] = 0;
                        m_next = (pick + 1) % W;
                    end else begin
                        m_ov = 0;
                    end
                end else begin
                    for (int k = 0; k < W; k++) if (fresh[k]) m_wait[k] = 1;
                end
            end

            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_ov); end
            checks++; if (m_ov && out_index !== 32'(m_idx)) begin errors++; $display("FAIL rand_index cyc=%0d got=%0d exp=%0d", cyc, out_index, m_idx); end
            checks++; if (hit_count !== 6'(m_cnt)) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, hit_count, m_cnt); end
            checks++; if (all_covered !== (m_cnt == W)) begin errors++; $display("FAIL rand_all cyc=%0d got=%0b exp=%0b", cyc, all_covered, (m_cnt == W)); end
        end
        valid = '0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_round_robin();
        test_backpressure();
        test_all_bits();
        test_en_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cover_toggle_drain.md
Name: cover_toggle_drain

Overview:
- Collects toggle-coverage hit bits from one coverage group of WIDTH points.
- Keeps each point's hit until it is reported, and reports each point only once.
- Drains hits one per cycle, round-robin, as global cover indices on a valid/ready channel.
- Sits between a group's per-bit valid vector and a single shared coverage-report sink, such as the DPI bridge or the formal cover collector.

Parameters:
- WIDTH, 40, number of cover points in the group (1..256).
- COVER_INDEX, 0, global index of bit 0.
- COVER_TOTAL, 8744, total cover points in the design; the constraint is COVER_INDEX+WIDTH <= COVER_TOTAL.
- IDX_W, 32, width of out_index.

Ports:
- clock, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset; 0 clears all state immediately.
- en, input, 1, 1 = accept new hits; 0 = ignore valid, but already-pending hits still drain.
- clear, input, 1, synchronous: wipe the seen map and pending hits, restart coverage.
- valid, input, WIDTH, per-point hit strobes, sampled every cycle.
- out_valid, output, 1, out_index holds a report.
- out_ready, input, 1, sink accepts the report.
- out_index, output, IDX_W, COVER_INDEX + selected bit, zero-extended.
- hit_count, output, clog2(WIDTH+1), number of reports accepted since reset or clear.
- all_covered, output, 1, hit_count == WIDTH.

Behaviour:
- State:
  - seen[WIDTH]: point reported or in flight.
  - pending[WIDTH]
  - ptr, clog2(WIDTH) bits
  - out register: out_valid, out_bit
  - hit_count
- Reset (reset=0, asynchronous):
  - seen, pending, ptr, out_valid, out_index, hit_count are all 0; all_covered = 0.
  - Outputs stay 0 while reset is low; normal operation starts at the first edge after release.
  - Reset mid-report drops the in-flight report with no handshake.
- New hits: newhit = valid & ~seen & {WIDTH{en}}, using seen before the edge.
- Load condition: load = !out_valid || (out_valid && out_ready).
- Selection when load and pending != 0:
  - sel is the first set pending bit at or after ptr, scanning upward and wrapping WIDTH-1 to 0.
  - At the edge: out_valid=1, out_bit=sel, seen[sel]=1, ptr = (sel+1) mod WIDTH.
- Selection when load and pending == 0: out_valid becomes 0 at the edge.
- pending update each edge: pending = (pending | newhit) & ~onehot(sel if loading).
  - A valid strobe on a bit being loaded that cycle does not re-pend it.
- Handshake:
  - out_valid and out_index hold stable until out_ready=1.
  - On acceptance, hit_count increments by 1, saturating at WIDTH.
  - Back-to-back reports proceed at one per cycle while out_ready=1.
- Latency: a hit sampled at edge N (pending at N) can appear on out_valid after edge N+1 at the earliest. No combinational path from valid to outputs.
- Arithmetic: out_index = COVER_INDEX + out_bit, computed in IDX_W bits; wrap beyond IDX_W is not permitted by parameter constraints.
- clear=1 at an edge:
  - seen=0, pending=0, ptr=0, hit_count=0; same-cycle valid bits are discarded.
  - An in-flight out register is kept and completes its handshake normally.
  - That completing handshake does not increment hit_count and does not set seen.
  - clear has priority over hit capture, load and count.
- Repeated strobes of a point already seen are ignored; each point yields exactly one report per reset/clear epoch.
- all_covered is registered; it stays 1 until reset or clear.

Test Plan:
1. Single hit: reset release, en=1, out_ready=1, valid=bit 5 for one cycle, COVER_INDEX=100.
   - out_valid=1 two edges later with out_index=105, for one cycle; hit_count=1.
   - Pulse valid bit 5 again: no further report.
2. Round-robin and wrap: WIDTH=40, ptr starts at 0, valid = bits {0, 3, 39} in one cycle, out_ready=1.
   - Reports 0, 3, 39 on consecutive cycles.
   - Then valid = bits {1, 38}: report order is 1, 38, since ptr=0 after wrap.
3. Backpressure: out_ready=0 with 3 hits pending.
   - out_valid=1 and out_index is stable for 10 cycles; no loss.
   - Release: three reports in 3 cycles; hit_count=3.
4. All 40 bits strobed in one cycle, out_ready=1.
   - 40 reports, indices COVER_INDEX+0..+39, in 40 consecutive cycles.
   - all_covered=1 after the last acceptance; hit_count=40.
5. en=0 strobes produce no reports.
   - clear mid-stream with out_valid=1 (index 7) and 2 hits pending: index 7 still completes its handshake, the 2 pending hits vanish, hit_count=0.
   - Re-strobing bit 7 reports it again.
6. Async reset asserted while out_valid=1 and out_ready=0: out_valid drops immediately with no clock edge.
   - All counters read 0 after release.
